// File: rtl/thermo_decode_monitor.sv
// Thermometer-code receiver: samples a 15-bit fill, bubble-corrects it by popcount,
// filters for stability, classifies accepted steps and keeps a saturating error count.
module thermo_decode_monitor #(
  parameter int unsigned STABLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [14:0]      thermo_in,
  input  logic             clear_err,
  output logic [3:0]       bin_out,
  output logic             valid,
  output logic [1:0]       dir,
  output logic             bubble_err,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0]       STABLE_N = 4'(STABLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_JUMP = 2'b11
  } dir_e;

  logic [14:0]      thermo_q,  thermo_d;
  logic             smp_vld_q, smp_vld_d;
  logic [3:0]       cand_q,    cand_d;
  logic             cand_vld_q, cand_vld_d;
  logic             bub_q,     bub_d;
  logic [3:0]       stab_q,    stab_d;
  logic [3:0]       bin_q,     bin_d;
  logic             valid_q,   valid_d;
  dir_e             dir_q,     dir_d;
  logic             bubble_err_q, bubble_err_d;
  logic             step_err_q,   step_err_d;
  logic [ERR_W-1:0] err_q,     err_d;

  logic [3:0]       pop;
  logic             legal;
  logic             accept;
  logic [3:0]       delta;

  always_comb begin
    pop = 4'd0;
    for (int i = 0; i < 15; i++) begin
      pop = pop + {3'b000, thermo_q[i]};
    end
    // A legal fill is 2^n-1: adding one clears every set bit.
    legal = ((thermo_q & (thermo_q + 15'd1)) == 15'd0);
  end

  always_comb begin
    thermo_d   = thermo_in;
    smp_vld_d  = 1'b1;

    cand_d     = cand_q;
    bub_d      = bub_q;
    stab_d     = stab_q;
    cand_vld_d = cand_vld_q;
    if (smp_vld_q) begin
      cand_d     = pop;
      bub_d      = ~legal;
      cand_vld_d = 1'b1;
      if (!cand_vld_q || (pop != cand_q)) begin
        stab_d = 4'd1;
      end else if (stab_q >= STABLE_N) begin
        stab_d = STABLE_N;
      end else begin
        stab_d = stab_q + 4'd1;
      end
    end

    accept       = cand_vld_q && (stab_q == STABLE_N);
    delta        = cand_q - bin_q;
    bubble_err_d = bub_q;
    bin_d        = bin_q;
    valid_d      = valid_q;
    dir_d        = dir_q;
    step_err_d   = 1'b0;
    if (accept) begin
      bin_d   = cand_q;
      valid_d = 1'b1;
      if (!valid_q) begin
        dir_d = DIR_HOLD;
      end else begin
        case (delta)
          4'd0:    dir_d = DIR_HOLD;
          4'd1:    dir_d = DIR_UP;
          4'd15:   dir_d = DIR_DOWN;
          default: begin
            dir_d      = DIR_JUMP;
            step_err_d = 1'b1;
          end
        endcase
      end
    end

    // Clear has priority over a coincident error event.
    if (clear_err) begin
      err_d = '0;
    end else if ((bubble_err_q || step_err_q) && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thermo_q     <= '0;
      smp_vld_q    <= 1'b0;
      cand_q       <= '0;
      cand_vld_q   <= 1'b0;
      bub_q        <= 1'b0;
      stab_q       <= '0;
      bin_q        <= '0;
      valid_q      <= 1'b0;
      dir_q        <= DIR_HOLD;
      bubble_err_q <= 1'b0;
      step_err_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      thermo_q     <= thermo_d;
      smp_vld_q    <= smp_vld_d;
      cand_q       <= cand_d;
      cand_vld_q   <= cand_vld_d;
      bub_q        <= bub_d;
      stab_q       <= stab_d;
      bin_q        <= bin_d;
      valid_q      <= valid_d;
      dir_q        <= dir_d;
      bubble_err_q <= bubble_err_d;
      step_err_q   <= step_err_d;
      err_q        <= err_d;
    end
  end

  assign bin_out    = bin_q;
  assign valid      = valid_q;
  assign dir        = dir_q;
  assign bubble_err = bubble_err_q;
  assign step_err   = step_err_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_thermo_decode_monitor.sv
// Directed bench for thermo_decode_monitor: one default instance and one with a
// three-sample stability filter and a 2-bit error counter.
module tb_thermo_decode_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] thermo = '0;
  logic        clr = 1'b0;
  logic [3:0]  bin;
  logic        vld;
  logic [1:0]  dir;
  logic        bub;
  logic        stp;
  logic [7:0]  errc;

  logic        rst3 = 1'b0;
  logic [14:0] thermo3 = '0;
  logic        clr3 = 1'b0;
  logic [3:0]  bin3;
  logic        vld3;
  logic [1:0]  dir3;
  logic        bub3;
  logic        stp3;
  logic [1:0]  errc3;

  int checks = 0;
  int errors = 0;

  thermo_decode_monitor #(.STABLE_CYCLES(1), .ERR_W(8)) u_dut (
    .clk(clk), .reset(rst), .thermo_in(thermo), .clear_err(clr),
    .bin_out(bin), .valid(vld), .dir(dir), .bubble_err(bub),
    .step_err(stp), .err_count(errc)
  );

  thermo_decode_monitor #(.STABLE_CYCLES(3), .ERR_W(2)) u_dut3 (
    .clk(clk), .reset(rst3), .thermo_in(thermo3), .clear_err(clr3),
    .bin_out(bin3), .valid(vld3), .dir(dir3), .bubble_err(bub3),
    .step_err(stp3), .err_count(errc3)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] therm(input int n);
    logic [15:0] t;
    t = (16'd1 << n) - 16'd1;
    return t[14:0];
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_bin", int'(bin), 0);
    check_eq("rst_vld", int'(vld), 0);
    check_eq("rst_dir", int'(dir), 0);
    check_eq("rst_bub", int'(bub), 0);
    check_eq("rst_stp", int'(stp), 0);
    check_eq("rst_err", int'(errc), 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: held 11
    thermo = 15'h07FF;
    do_reset();
    step();
    check_eq("t1_vld_e1", int'(vld), 0);
    step();
    check_eq("t1_vld_e2", int'(vld), 0);
    step();
    check_eq("t1_bin", int'(bin), 11);
    check_eq("t1_vld", int'(vld), 1);
    check_eq("t1_dir", int'(dir), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t1_hold_bin", int'(bin), 11);
      check_eq("t1_hold_dir", int'(dir), 0);
      check_eq("t1_hold_bub", int'(bub), 0);
      check_eq("t1_hold_stp", int'(stp), 0);
    end
    check_eq("t1_err", int'(errc), 0);

    // Test 2: count up 0..15 and wrap to 0
    thermo = 15'h0000;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check_eq("t2_start_bin", int'(bin), 0);
    for (int k = 1; k <= 18; k++) begin
      thermo = therm((k <= 16) ? (k % 16) : 0);
      step();
      if (k >= 3) begin
        check_eq("t2_up_bin", int'(bin), (k - 2) % 16);
        check_eq("t2_up_dir", int'(dir), 1);
      end
      check_eq("t2_up_stp", int'(stp), 0);
    end
    check_eq("t2_err", int'(errc), 0);

    // Test 3: count down from 0 through 15 back to 0
    thermo = 15'h0000;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    for (int k = 1; k <= 18; k++) begin
      thermo = therm((16 - ((k <= 16) ? k : 16)) % 16);
      step();
      if (k >= 3) begin
        check_eq("t3_dn_bin", int'(bin), (16 - (k - 2)) % 16);
        check_eq("t3_dn_dir", int'(dir), 2);
      end
      check_eq("t3_dn_stp", int'(stp), 0);
      check_eq("t3_dn_bub", int'(bub), 0);
    end
    check_eq("t3_err", int'(errc), 0);

    // Test 4: bubble code 007B between 6 and 7
    thermo = 15'h003F;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check_eq("t4_start_bin", int'(bin), 6);
    thermo = 15'h007B;
    step();
    thermo = 15'h007F;
    step();
    check_eq("t4_pre_bub", int'(bub), 0);
    step();
    check_eq("t4_bub_pulse", int'(bub), 1);
    check_eq("t4_bub_bin", int'(bin), 6);
    check_eq("t4_bub_stp", int'(stp), 0);
    check_eq("t4_bub_err0", int'(errc), 0);
    step();
    check_eq("t4_bub_end", int'(bub), 0);
    check_eq("t4_bin7", int'(bin), 7);
    check_eq("t4_dir_up", int'(dir), 1);
    check_eq("t4_err1", int'(errc), 1);
    step();
    check_eq("t4_err_hold", int'(errc), 1);
    check_eq("t4_stp", int'(stp), 0);

    // Test 5: jump 3->9, then jump 9->3 with coincident clear
    thermo = 15'h0007;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check_eq("t5_start_bin", int'(bin), 3);
    thermo = 15'h01FF;
    step();
    step();
    check_eq("t5_pre_stp", int'(stp), 0);
    step();
    check_eq("t5_jump_bin", int'(bin), 9);
    check_eq("t5_jump_dir", int'(dir), 3);
    check_eq("t5_jump_stp", int'(stp), 1);
    check_eq("t5_jump_err0", int'(errc), 0);
    step();
    check_eq("t5_stp_end", int'(stp), 0);
    check_eq("t5_err1", int'(errc), 1);
    check_eq("t5_dir_hold", int'(dir), 0);
    thermo = 15'h0007;
    step();
    step();
    step();
    check_eq("t5_jump2_bin", int'(bin), 3);
    check_eq("t5_jump2_dir", int'(dir), 3);
    check_eq("t5_jump2_stp", int'(stp), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("t5_clr_wins", int'(errc), 0);
    step();
    check_eq("t5_clr_stays", int'(errc), 0);

    // Test 6: three-sample filter, glitch rejection, mid-stream reset
    thermo3 = 15'h000F;
    rst3 = 1'b0;
    #1;
    rst3 = 1'b1;
    #1;
    check_eq("t6_rst_bin", int'(bin3), 0);
    check_eq("t6_rst_vld", int'(vld3), 0);
    step();
    rst3 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("t6_vld_wait", int'(vld3), 0);
    step();
    check_eq("t6_acc_vld", int'(vld3), 1);
    check_eq("t6_acc_bin", int'(bin3), 4);
    check_eq("t6_acc_dir", int'(dir3), 0);
    step();
    step();
    thermo3 = 15'h00FF;
    step();
    thermo3 = 15'h000F;
    for (int i = 0; i < 7; i++) begin
      check_eq("t6_glitch_bin", int'(bin3), 4);
      check_eq("t6_glitch_dir", int'(dir3), 0);
      check_eq("t6_glitch_stp", int'(stp3), 0);
      step();
    end
    check_eq("t6_glitch_err", int'(errc3), 0);
    thermo3 = 15'h00FF;
    step();
    step();
    rst3 = 1'b1;
    #1;
    check_eq("t6_mid_bin", int'(bin3), 0);
    check_eq("t6_mid_vld", int'(vld3), 0);
    check_eq("t6_mid_dir", int'(dir3), 0);
    check_eq("t6_mid_stp", int'(stp3), 0);
    check_eq("t6_mid_bub", int'(bub3), 0);
    check_eq("t6_mid_err", int'(errc3), 0);
    step();
    rst3 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("t6_post_wait", int'(vld3), 0);
    step();
    check_eq("t6_post_vld", int'(vld3), 1);
    check_eq("t6_post_bin", int'(bin3), 8);
    check_eq("t6_post_dir", int'(dir3), 0);
    check_eq("t6_post_stp", int'(stp3), 0);

    // Saturation of the 2-bit counter under a continuous bubble
    thermo3 = 15'h0005;
    for (int i = 0; i < 8; i++) step();
    check_eq("t7_bub_on", int'(bub3), 1);
    check_eq("t7_sat", int'(errc3), 3);
    clr3 = 1'b1;
    step();
    clr3 = 1'b0;
    check_eq("t7_clr", int'(errc3), 0);
    step();
    check_eq("t7_recount", int'(errc3), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thermo_decode_monitor.md
Name: thermo_decode_monitor

Overview:
- Receive-side counterpart of the thermometer-coded counter: samples a 15-bit thermometer count, bubble-corrects and decodes it to 4-bit binary.
- Applies an optional stability filter, then classifies each accepted step as hold, up, down or illegal jump.
- Flags bubble and step errors and keeps a saturating error count for board-level status LEDs and debug.

Parameters:
- STABLE_CYCLES, 1, consecutive identical decoded samples required before acceptance (legal 1..15).
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- thermo_in  input  15  thermometer code; bit0 is the LSB of the fill.
- clear_err  input  1  synchronous clear of err_count.
- bin_out  output  4  accepted decoded value.
- valid  output  1  high once the first value has been accepted after reset.
- dir  output  2  last accepted step: 00 hold, 01 up, 10 down, 11 jump.
- bubble_err  output  1  one-cycle pulse: the sampled code was not a legal thermometer code.
- step_err  output  1  one-cycle pulse: an accepted step was a jump.
- err_count  output  ERR_W  saturating count of error events.

Behaviour:
- Reset (asynchronous, takes effect immediately; applies equally mid-stream):
  - All registers clear: bin_out=0, valid=0, dir=00, bubble_err=0, step_err=0, err_count=0.
  - Internal sample, candidate and stability-counter registers also clear.
- Stage 1, edge k: r_thermo <= thermo_in. There is no combinational path from input to output.
- Stage 2, edge k+1:
  - cand <= popcount(r_thermo), range 0..15. This is the bubble correction.
  - bub <= 1 if r_thermo is not of the form (2^n)-1 for n=0..15.
  - stab_cnt <= min(stab_cnt+1, STABLE_CYCLES) if the new cand equals the previous cand; otherwise 1. After reset the first sample loads 1.
- Stage 3, edge k+2:
  - bubble_err <= bub, on every sample, independent of acceptance.
  - Accept when stab_cnt == STABLE_CYCLES: bin_out <= cand, valid <= 1, and dir/step_err are updated per the next item.
  - When not accepted, bin_out and dir hold and step_err=0.
- Step classification on acceptance, d = (cand − bin_out) mod 16:
  - d=0: dir=00.
  - d=1: dir=01. This includes the wrap 15→0.
  - d=15: dir=10. This includes the wrap 0→15.
  - Otherwise: dir=11 and step_err=1 for one cycle.
  - First acceptance after reset (valid was 0): dir=00, step_err=0, regardless of value.
- Latency: 1+STABLE_CYCLES clocks from a stable thermo_in to bin_out. With STABLE_CYCLES=1 this is 2 clocks, one new value per clock, full throughput.
- err_count:
  - Increments by exactly 1 in any cycle where bubble_err or step_err is asserted; both together still count 1.
  - Saturates at 2^ERR_W−1.
  - clear_err=1 forces it to 0 on the next edge. Clear wins over a simultaneous increment.
- Held-code behaviour: when thermo_in is constant and stable it re-accepts each cycle with dir=00. No pulses are produced.
- Glitch behaviour: a candidate that changes before reaching STABLE_CYCLES is discarded. bin_out is unaffected, but a bubble in the glitch still pulses bubble_err.

Test Plan:
1. Reset, then thermo_in=15'h07FF held: 2 clocks after the first sample, bin_out=11, valid=1, dir=00. bubble_err, step_err and err_count stay 0.
2. Up sequence 15'h0000, 15'h0001, 15'h0003 … 15'h7FFF, 15'h0000, one per clock: bin_out steps 0..15 then 0. dir=01 on every step including the wrap. step_err never asserts.
3. Down sequence 15'h0000, 15'h7FFF, 15'h3FFF, …: bin_out shows 0, 15, 14, …. dir=10 throughout including 0→15. No errors.
4. Bubble: from bin_out=6 (15'h003F), apply 15'h007B (popcount 6), then 15'h007F: bubble_err pulses once aligned to the 15'h007B sample, bin_out=6 then 7, err_count=1, no step_err.
5. Jump: 15'h0007 → 15'h01FF (3→9): dir=11, step_err one-cycle pulse, err_count increments. Then clear_err pulsed in the same cycle as another jump: err_count=0.
6. STABLE_CYCLES=3 instance: 15'h000F held, then a 1-cycle glitch of 15'h00FF, then 15'h000F again. bin_out stays 4 with no dir change. Assert reset mid-stream: all outputs are 0 immediately, and the first post-reset acceptance gives dir=00 with step_err=0.
